alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU with a start/done handshake, a persistent accumulator and N/Z/C/V status flags. It replaces the fixed 8-bit ALU behind the control module: accepts one operation per handshake, executes single-cycle or iterative ops, and returns a registered result. Adds configurable width, carry chaining, iterative shifts, back-to-back issue and an optional iterative multiplier.

## Interface
- WIDTH, 8: operand/result width, ≥4, power of two.
- CW, $clog2(WIDTH): shift-count width, derived, not overridden.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  4  opcode, captured with start.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- use_acc  in  1  1: operand B taken from acc at capture instead of b.
- ready  out  1  state==IDLE.
- result  out  WIDTH  last completed result.
- acc  out  WIDTH  accumulator.
- flags  out  4  {N,Z,C,V}.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-op pulse, coincident with done.

## Operation
- States: IDLE, EXEC, ITER.
- IDLE & start: latch op, A, B (acc if use_acc) -> EXEC. start while not ready is ignored.
- Opcodes: 0 PASS A; 1 INC A; 2 ADD; 3 SUB A−B; 4 DEC A; 5 NOT A; 6 AND; 7 OR; 8 XOR; 9 ADC A+B+C; 10 SHL; 11 SHR (logical); 12 ROL; 13 MAX unsigned; 14 MUL (low WIDTH bits); 15 NOP.
- EXEC, ops 0–9, 13: compute, complete -> IDLE.
- EXEC, ops 10–12: n = B[CW-1:0], higher B bits ignored. n=0 completes immediately with A, C=0. Otherwise -> ITER: one bit per cycle, count decrements, completes on the 1->0 step.
- EXEC, op 14: -> ITER, shift-add for WIDTH cycles, then complete.
- Completion edge: result, acc, flags are written, done<=1, state<=IDLE. NOP writes nothing but still pulses done.
- Flags:
  - Z: result==0.
  - N: result MSB.
  - C: carry out for ADD/INC/ADC; borrow for SUB/DEC; last bit shifted or rotated out; MUL C=1 if the high half is nonzero; 0 otherwise.
  - V: signed overflow for ADD/INC/ADC/SUB/DEC; 0 otherwise.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset (rst_n low, any state): state IDLE, ready=1, result=0, acc=0, flags=0, done=0, err=0. Takes effect immediately. An in-flight op is discarded with no done.
- Start sampled at edge E0. Single-cycle op: outputs and done valid after E1.
- Shift by n≥1: done after E(n+1). MUL: done after E(WIDTH+1).
- done is high for exactly one cycle. ready is high in that same cycle, so a start there is accepted: one op every 2 cycles minimum.
- use_acc samples acc at E0, including an acc value written on E0's preceding completion edge.
- ADC uses the C flag as it stands at E1.

## Configuration
- ALU_MUL_EN defined: op 14 is the iterative multiplier above.
- ALU_MUL_EN undefined:
  - No multiplier logic is built.
  - op 14 completes at E1 with err=1 and done=1.
  - result, acc and flags are unchanged.

## Test plan
- ADD a=0xF0, b=0x20 (WIDTH=8) -> result=0x10, C=1, Z=0, N=0, V=0; done one cycle, after E1.
- SUB a=0x80, b=0x01 -> 0x7F, V=1, C=0, N=0. Then DEC a=0x00 -> 0xFF, C=1, N=1.
- SHL a=0x81, b=0x03 -> 0x08, C=0; done after E4. A start pulsed at E2 is ignored; a start during the done cycle is accepted.
- Chaining: ADD 0xFF+0x01 (C=1, Z=1). Then ADC a=0x00, b=0x00 -> 0x01. Then ADD a=0x02, use_acc=1 -> 0x03.
- MUL 0x10×0x10 with ALU_MUL_EN -> 0x00, Z=1, C=1, done after E9. Without the macro -> err=1 at E1, acc unchanged.
- rst_n low mid-MUL at E4 -> outputs 0, ready=1, no done. A new ADD 0x01+0x01 after release -> 0x02.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/done handshake, persistent accumulator and {N,Z,C,V} flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 14.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW   = $clog2(WIDTH);
    localparam int unsigned CntW = CW + 1;
    localparam int unsigned Msb  = WIDTH - 1;

    localparam logic [3:0] OpPass = 4'd0;
    localparam logic [3:0] OpInc  = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpDec  = 4'd4;
    localparam logic [3:0] OpNot  = 4'd5;
    localparam logic [3:0] OpAnd  = 4'd6;
    localparam logic [3:0] OpOr   = 4'd7;
    localparam logic [3:0] OpXor  = 4'd8;
    localparam logic [3:0] OpAdc  = 4'd9;
    localparam logic [3:0] OpShl  = 4'd10;
    localparam logic [3:0] OpShr  = 4'd11;
    localparam logic [3:0] OpRol  = 4'd12;
    localparam logic [3:0] OpMax  = 4'd13;
    localparam logic [3:0] OpMul  = 4'd14;
    localparam logic [3:0] OpNop  = 4'd15;

    localparam logic [CntW-1:0] CntOne = {{CW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StExec, StIter} state_e;

    state_e              state_q;
    logic [3:0]          op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [CntW-1:0]     cnt_q;

    logic [WIDTH:0]      ex_sum;
    logic [WIDTH-1:0]    ex_res;
    logic                ex_c;
    logic                ex_v;
    logic                is_shift;
    logic [CW-1:0]       shamt;
    logic [WIDTH-1:0]    step_res;
    logic                step_c;
    logic [WIDTH-1:0]    iter_res;
    logic                iter_c;

`ifdef ALU_MUL_EN
    localparam logic [CntW-1:0] MulCnt = CntW'(WIDTH);

    logic [2*WIDTH-1:0]  prod_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [2*WIDTH-1:0]  prod_next;

    assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);
`endif

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    assign ready    = (state_q == StIdle);
    assign is_shift = (op_q == OpShl) || (op_q == OpShr) || (op_q == OpRol);
    assign shamt    = b_q[CW-1:0];

    // Single-cycle datapath; shifts with a zero count fall through to pass A with C=0.
    always_comb begin
        ex_sum = '0;
        ex_res = a_q;
        ex_c   = 1'b0;
        ex_v   = 1'b0;
        case (op_q)
            OpPass: ex_res = a_q;
            OpInc: begin
                ex_sum = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
                ex_res = ex_sum[WIDTH-1:0];
                ex_c   = ex_sum[WIDTH];
                ex_v   = ~a_q[Msb] & ex_res[Msb];
            end
            OpAdd: begin
                ex_sum = {1'b0, a_q} + {1'b0, b_q};
                ex_res = ex_sum[WIDTH-1:0];
                ex_c   = ex_sum[WIDTH];
                ex_v   = (a_q[Msb] == b_q[Msb]) && (ex_res[Msb] != a_q[Msb]);
            end
            OpSub: begin
                ex_sum = {1'b0, a_q} - {1'b0, b_q};
                ex_res = ex_sum[WIDTH-1:0];
                ex_c   = ex_sum[WIDTH];
                ex_v   = (a_q[Msb] != b_q[Msb]) && (ex_res[Msb] != a_q[Msb]);
            end
            OpDec: begin
                ex_sum = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
                ex_res = ex_sum[WIDTH-1:0];
                ex_c   = ex_sum[WIDTH];
                ex_v   = a_q[Msb] & ~ex_res[Msb];
            end
            OpNot: ex_res = ~a_q;
            OpAnd: ex_res = a_q & b_q;
            OpOr:  ex_res = a_q | b_q;
            OpXor: ex_res = a_q ^ b_q;
            OpAdc: begin
                ex_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, flags[1]};
                ex_res = ex_sum[WIDTH-1:0];
                ex_c   = ex_sum[WIDTH];
                ex_v   = (a_q[Msb] == b_q[Msb]) && (ex_res[Msb] != a_q[Msb]);
            end
            OpMax:   ex_res = (a_q >= b_q) ? a_q : b_q;
            default: ex_res = a_q;
        endcase
    end

    always_comb begin
        step_res = {a_q[WIDTH-2:0], a_q[Msb]};
        step_c   = a_q[Msb];
        case (op_q)
            OpShl: begin
                step_res = {a_q[WIDTH-2:0], 1'b0};
                step_c   = a_q[Msb];
            end
            OpShr: begin
                step_res = {1'b0, a_q[WIDTH-1:1]};
                step_c   = a_q[0];
            end
            default: begin
                step_res = {a_q[WIDTH-2:0], a_q[Msb]};
                step_c   = a_q[Msb];
            end
        endcase
    end

    always_comb begin
        iter_res = step_res;
        iter_c   = step_c;
`ifdef ALU_MUL_EN
        if (op_q == OpMul) begin
            iter_res = prod_next[WIDTH-1:0];
            iter_c   = |prod_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            result  <= '0;
            acc     <= '0;
            flags   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= use_acc ? acc : b;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (op_q == OpNop) begin
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end else if (op_q == OpMul) begin
`ifdef ALU_MUL_EN
                        prod_q  <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, a_q};
                        cnt_q   <= MulCnt;
                        state_q <= StIter;
`else
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StIdle;
`endif
                    end else if (is_shift && (shamt != '0)) begin
                        cnt_q   <= {1'b0, shamt};
                        state_q <= StIter;
                    end else begin
                        result  <= ex_res;
                        acc     <= ex_res;
                        flags   <= mk_flags(ex_res, ex_c, ex_v);
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StIter: begin
                    cnt_q <= cnt_q - CntOne;
                    a_q   <= step_res;
`ifdef ALU_MUL_EN
                    prod_q  <= prod_next;
                    mcand_q <= mcand_q << 1;
                    b_q     <= b_q >> 1;
`endif
                    // Completion happens on the 1 -> 0 count step.
                    if (cnt_q == CntOne) begin
                        result  <= iter_res;
                        acc     <= iter_res;
                        flags   <= mk_flags(iter_res, iter_c, 1'b0);
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); tracks ALU_MUL_EN for op 14.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       ready;
    logic [7:0] result;
    logic [7:0] acc;
    logic [3:0] flags;
    logic       done;
    logic       err;

    int checks;
    int errors;

    alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .use_acc (use_acc),
        .ready   (ready),
        .result  (result),
        .acc     (acc),
        .flags   (flags),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] fl;
        logic [3:0] lat;
    } vec_t;

    // Called at a negedge; returns at the negedge where done is seen (the done cycle).
    task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic ua, output int lat, output logic e);
        op = o; a = av; b = bv; use_acc = ua; start = 1'b1;
        @(negedge clk);
        start = 1'b0; use_acc = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = err;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (result !== 8'h00 || acc !== 8'h00) begin errors++; $display("FAIL reset_regs: result %h acc %h expected 00 00", result, acc); end
        checks++; if (flags !== 4'h0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctl: flags %h done %b err %b expected 0 0 0", flags, done, err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat; logic e;
        run_op(4'd2, 8'hF0, 8'h20, 1'b0, lat, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
        checks++; if (result !== 8'h10) begin errors++; $display("FAIL add_result: got %h expected 10", result); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL add_flags: got %b expected 0010", flags); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add_ready_in_done: got %b expected 1", ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_width: got %b expected 0", done); end
    endtask

    task automatic test_sub_dec;
        int lat; logic e;
        run_op(4'd3, 8'h80, 8'h01, 1'b0, lat, e);
        checks++; if (result !== 8'h7F || flags !== 4'b0001) begin errors++; $display("FAIL sub_ovf: got %h/%b expected 7f/0001", result, flags); end
        run_op(4'd4, 8'h00, 8'h00, 1'b0, lat, e);
        checks++; if (result !== 8'hFF || flags !== 4'b1010) begin errors++; $display("FAIL dec_borrow: got %h/%b expected ff/1010", result, flags); end
        checks++; if (acc !== 8'hFF) begin errors++; $display("FAIL dec_acc: got %h expected ff", acc); end
    endtask

    task automatic test_ops;
        vec_t vecs[12];
        int lat; logic e;
        vecs[0]  = '{4'd0,  8'hA5, 8'h00, 8'hA5, 4'b1000, 4'd1};
        vecs[1]  = '{4'd1,  8'h7F, 8'h00, 8'h80, 4'b1001, 4'd1};
        vecs[2]  = '{4'd1,  8'hFF, 8'h00, 8'h00, 4'b0110, 4'd1};
        vecs[3]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 4'b1000, 4'd1};
        vecs[4]  = '{4'd6,  8'hF0, 8'h3C, 8'h30, 4'b0000, 4'd1};
        vecs[5]  = '{4'd7,  8'hF0, 8'h0F, 8'hFF, 4'b1000, 4'd1};
        vecs[6]  = '{4'd8,  8'hAA, 8'hAA, 8'h00, 4'b0100, 4'd1};
        vecs[7]  = '{4'd13, 8'h80, 8'h7F, 8'h80, 4'b1000, 4'd1};
        vecs[8]  = '{4'd11, 8'h81, 8'h01, 8'h40, 4'b0010, 4'd2};
        vecs[9]  = '{4'd12, 8'h81, 8'h02, 8'h06, 4'b0000, 4'd3};
        vecs[10] = '{4'd10, 8'h81, 8'h08, 8'h81, 4'b1000, 4'd1};
        vecs[11] = '{4'd12, 8'h80, 8'hF9, 8'h01, 4'b0010, 4'd2};
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, e);
            checks++; if (result !== vecs[i].res) begin errors++; $display("FAIL ops_result[%0d]: got %h expected %h", i, result, vecs[i].res); end
            checks++; if (flags !== vecs[i].fl) begin errors++; $display("FAIL ops_flags[%0d]: got %b expected %b", i, flags, vecs[i].fl); end
            checks++; if (lat !== int'(vecs[i].lat) || e !== 1'b0) begin errors++; $display("FAIL ops_timing[%0d]: lat %0d err %b expected %0d 0", i, lat, e, vecs[i].lat); end
        end
    endtask

    task automatic test_shift_handshake;
        int cyc; int lat; logic e;
        op = 4'd10; a = 8'h81; b = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL shl_busy: ready %b expected 0", ready); end
        @(negedge clk);
        cyc = 1; op = 4'd2; a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        cyc = 2; start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL shl_latency: got %0d expected 4", cyc); end
        checks++; if (result !== 8'h08 || flags !== 4'b0000) begin errors++; $display("FAIL shl_result: got %h/%b expected 08/0000", result, flags); end
        run_op(4'd0, 8'h55, 8'h00, 1'b0, lat, e);
        checks++; if (lat !== 1 || result !== 8'h55) begin errors++; $display("FAIL back_to_back: lat %0d result %h expected 1 55", lat, result); end
    endtask

    task automatic test_chain;
        int lat; logic e;
        run_op(4'd2, 8'hFF, 8'h01, 1'b0, lat, e);
        checks++; if (result !== 8'h00 || flags !== 4'b0110) begin errors++; $display("FAIL chain_add: got %h/%b expected 00/0110", result, flags); end
        run_op(4'd9, 8'h00, 8'h00, 1'b0, lat, e);
        checks++; if (result !== 8'h01 || flags !== 4'b0000) begin errors++; $display("FAIL chain_adc: got %h/%b expected 01/0000", result, flags); end
        run_op(4'd2, 8'h02, 8'hF0, 1'b1, lat, e);
        checks++; if (result !== 8'h03 || acc !== 8'h03) begin errors++; $display("FAIL chain_use_acc: result %h acc %h expected 03 03", result, acc); end
    endtask

    task automatic test_nop;
        int lat; logic e;
        run_op(4'd15, 8'hFF, 8'hFF, 1'b0, lat, e);
        checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL nop_done: lat %0d err %b expected 1 0", lat, e); end
        checks++; if (result !== 8'h03 || acc !== 8'h03 || flags !== 4'b0000) begin errors++; $display("FAIL nop_hold: %h %h %b expected 03 03 0000", result, acc, flags); end
    endtask

    task automatic test_mul;
        int lat; logic e;
        run_op(4'd0, 8'h3C, 8'h00, 1'b0, lat, e);
        run_op(4'd14, 8'h10, 8'h10, 1'b0, lat, e);
`ifdef ALU_MUL_EN
        checks++; if (lat !== 9 || e !== 1'b0) begin errors++; $display("FAIL mul_timing: lat %0d err %b expected 9 0", lat, e); end
        checks++; if (result !== 8'h00 || flags !== 4'b0110) begin errors++; $display("FAIL mul_result: got %h/%b expected 00/0110", result, flags); end
`else
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL mul_illegal: lat %0d err %b expected 1 1", lat, e); end
        checks++; if (acc !== 8'h3C || result !== 8'h3C || flags !== 4'b0000) begin errors++; $display("FAIL mul_hold: %h %h %b expected 3c 3c 0000", acc, result, flags); end
`endif
        @(negedge clk);
        checks++; if (err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul_pulse: err %b done %b expected 0 0", err, done); end
    endtask

    task automatic test_reset_midop;
        int lat; logic e; int seen;
        run_op(4'd0, 8'h11, 8'h00, 1'b0, lat, e);
`ifdef ALU_MUL_EN
        op = 4'd14; a = 8'h10; b = 8'h10;
`else
        op = 4'd10; a = 8'h01; b = 8'h07;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || result !== 8'h00 || acc !== 8'h00 || flags !== 4'h0) begin errors++; $display("FAIL midop_reset: ready %b result %h acc %h flags %b expected 1 00 00 0000", ready, result, acc, flags); end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midop_no_done: got %0d pulses expected 0", seen); end
        run_op(4'd2, 8'h01, 8'h01, 1'b0, lat, e);
        checks++; if (lat !== 1 || result !== 8'h02 || flags !== 4'b0000) begin errors++; $display("FAIL after_reset_add: lat %0d %h/%b expected 1 02/0000", lat, result, flags); end
    endtask

    initial begin
        checks = 0; errors = 0;
        start = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0; rst_n = 1'b0;
        test_reset;
        test_add;
        test_sub_dec;
        test_ops;
        test_shift_handshake;
        test_chain;
        test_nop;
        test_mul;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
